// File: rtl/shift_sub_divider_if.sv
// Start/done handshake and operand/result bus between the execute stage and
// the shift-subtract divider. The execute stage is the master; the divider
// is the slave.
interface shift_sub_divider_if #(
  parameter int W = 32
) ();
  logic         start;
  logic         br_mispredict;
  logic         div_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;

  modport master (
    output start, br_mispredict, div_signed, a, b,
    input  quotient, remainder, done
  );

  modport slave (
    input  start, br_mispredict, div_signed, a, b,
    output quotient, remainder, done
  );
endinterface

// File: rtl/shift_sub_divider.sv
// Iterative restoring shift-subtract divider for DIV/DIVU/REM/REMU.
// Operands are captured as magnitudes, one quotient bit is produced per
// CALC cycle, and the result sign is fixed up combinationally in DONE.
// Divide-by-zero and signed overflow bypass CALC and finish in one cycle.
module shift_sub_divider #(
  parameter int OPERAND_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  shift_sub_divider_if.slave bus
);
  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0]  MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W:0]    rem_q, rem_d;       // partial remainder, one guard bit
  logic [W-1:0]  quo_q, quo_d;       // dividend shifts out as quotient shifts in
  logic [W-1:0]  div_q, div_d;       // divisor magnitude
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_quo_q, neg_quo_d;
  logic          neg_rem_q, neg_rem_d;

  logic          a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;
  logic          b_zero, sgn_ovf;
  logic [W:0]    trial, diff;
  logic          fits;
  logic          done_w;

  // Operand conditioning: magnitudes and special-case detection at capture.
  always_comb begin
    a_neg   = bus.div_signed & bus.a[W-1];
    b_neg   = bus.div_signed & bus.b[W-1];
    a_mag   = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag   = b_neg ? (~bus.b + 1'b1) : bus.b;
    b_zero  = (bus.b == '0);
    sgn_ovf = bus.div_signed && (bus.a == MIN_NEG) && (bus.b == '1);
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    trial = {rem_q[W-1:0], quo_q[W-1]};
    diff  = trial - {1'b0, div_q};
    fits  = (trial >= {1'b0, div_q});
  end

  // Next-state and datapath update; a flush wins over everything else.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    if (bus.br_mispredict) begin
      state_d   = ST_IDLE;
      rem_d     = '0;
      quo_d     = '0;
      div_d     = '0;
      cnt_d     = '0;
      neg_quo_d = 1'b0;
      neg_rem_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            cnt_d = '0;
            div_d = '0;
            if (b_zero) begin
              // Result is stored already signed-correct, so no fix-up.
              quo_d     = '1;
              rem_d     = {1'b0, bus.a};
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = ST_DONE;
            end else if (sgn_ovf) begin
              quo_d     = bus.a;
              rem_d     = '0;
              neg_quo_d = 1'b0;
              neg_rem_d = 1'b0;
              state_d   = ST_DONE;
            end else begin
              quo_d     = a_mag;
              rem_d     = '0;
              div_d     = b_mag;
              neg_quo_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              state_d   = ST_CALC;
            end
          end
        end

        ST_CALC: begin
          quo_d = {quo_q[W-2:0], fits};
          rem_d = fits ? diff : trial;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end

        ST_DONE: begin
          if (!bus.start) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  // Results are visible only in DONE; negating zero stays zero.
  assign done_w        = (state_q == ST_DONE);
  assign bus.done      = done_w;
  assign bus.quotient  = !done_w ? '0 :
                         (neg_quo_q ? (~quo_q + 1'b1) : quo_q);
  assign bus.remainder = !done_w ? '0 :
                         (neg_rem_q ? (~rem_q[W-1:0] + 1'b1) : rem_q[W-1:0]);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Randomized and directed bench for shift_sub_divider. Expected results come
// from plain SV division; expected timing comes from the documented latency.
module tb_shift_sub_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_total = 0;
  int   n_bad = 0;

  // expectation of the transaction currently on the bus
  logic        chk_en = 1'b0;
  logic        tr_active = 1'b0;
  int          tr_s = 0;
  int          tr_lat = 0;
  int          tr_drop = 1000000;
  logic [31:0] tr_q = '0;
  logic [31:0] tr_r = '0;

  shift_sub_divider_if #(.W(32)) bus_if ();

  shift_sub_divider #(.OPERAND_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, got, want, cyc);
    end
  endtask

  // Reference: RISC-V M semantics via SV arithmetic plus documented latency.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output int lat);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    lat = 33;
    if (b == 32'd0) begin
      q = '1; r = a; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; lat = 1;
    end else if (s) begin
      q = sa / sb; r = sa % sb;
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Every cycle: done must be high exactly from start+latency until start drops.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_d;
      exp_d = tr_active && (cyc >= tr_s + tr_lat) && (cyc <= tr_drop);
      check("done", {31'd0, bus_if.done}, {31'd0, exp_d});
      check("quotient", bus_if.quotient, exp_d ? tr_q : 32'd0);
      check("remainder", bus_if.remainder, exp_d ? tr_r : 32'd0);
    end
  end

  task automatic begin_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    int lat;
    model(a, b, s, q, r, lat);
    @(posedge clk); #1;
    bus_if.a = a;
    bus_if.b = b;
    bus_if.div_signed = s;
    bus_if.start = 1'b1;
    tr_q = q;
    tr_r = r;
    tr_lat = lat;
    tr_s = cyc;
    tr_drop = 1000000;
    tr_active = 1'b1;
    $display("op a=%h b=%h signed=%0d expect q=%h r=%h latency=%0d", a, b, s, q, r, lat);
  endtask

  // Hold start through done plus extra cycles, scrambling operands meanwhile.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int extra);
    begin_op(a, b, s);
    for (int i = 0; i < tr_lat + extra; i++) begin
      @(posedge clk); #1;
      bus_if.a = $urandom;
      bus_if.b = $urandom;
      bus_if.div_signed = 1'($urandom_range(0, 1));
    end
    bus_if.start = 1'b0;
    tr_drop = cyc;
  endtask

  task automatic async_reset_pulse();
    chk_en = 1'b0;
    #1;
    rst = 1'b1;
    bus_if.start = 1'b0;
    #1;
    check("rst_done", {31'd0, bus_if.done}, 32'd0);
    check("rst_quotient", bus_if.quotient, 32'd0);
    check("rst_remainder", bus_if.remainder, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    tr_active = 1'b0;
    chk_en = 1'b1;
  endtask

  initial begin
    logic [31:0] pq, pr;
    int plat;
    logic [31:0] ra, rb;
    logic        rs;

    bus_if.start = 1'b0;
    bus_if.br_mispredict = 1'b0;
    bus_if.div_signed = 1'b0;
    bus_if.a = '0;
    bus_if.b = '0;

    // reference-model pins
    model(32'd100, 32'd7, 1'b0, pq, pr, plat);
    check("pin_u_q", pq, 32'd14);
    check("pin_u_r", pr, 32'd2);
    check("pin_u_lat", plat, 32'd33);
    model(32'hFFFF_FFF9, 32'd2, 1'b1, pq, pr, plat);
    check("pin_s1_q", pq, 32'hFFFF_FFFD);
    check("pin_s1_r", pr, 32'hFFFF_FFFF);
    model(32'd7, 32'hFFFF_FFFE, 1'b1, pq, pr, plat);
    check("pin_s2_q", pq, 32'hFFFF_FFFD);
    check("pin_s2_r", pr, 32'd1);
    model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, pq, pr, plat);
    check("pin_ovf_u_q", pq, 32'd0);
    check("pin_ovf_u_r", pr, 32'h8000_0000);

    // reset state
    #1;
    check("reset_done", {31'd0, bus_if.done}, 32'd0);
    check("reset_quotient", bus_if.quotient, 32'd0);
    check("reset_remainder", bus_if.remainder, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // directed operations
    run_op(32'd100, 32'd7, 1'b0, 3);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op(32'h1234, 32'd0, 1'b0, 2);
    run_op(32'h1234, 32'd0, 1'b1, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1);

    // flush in the 10th CALC cycle, then a normal op from IDLE
    begin_op(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    bus_if.br_mispredict = 1'b1;
    bus_if.start = 1'b0;
    tr_drop = cyc;
    @(posedge clk); #1;
    bus_if.br_mispredict = 1'b0;
    $display("flush issued at cycle %0d", tr_drop);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1);

    // async reset mid-CALC, then an op proves IDLE
    begin_op(32'd5000, 32'd9, 1'b1);
    repeat (6) @(posedge clk);
    async_reset_pulse();
    run_op(32'hFFFF_FF00, 32'd16, 1'b1, 0);

    // async reset while DONE: outputs must drop at once
    begin_op(32'h55, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    async_reset_pulse();
    run_op(32'd81, 32'd9, 1'b0, 0);

    // randomized operations
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = $urandom_range(0, 15);
        4: rb = -($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ra, rb, rs, $urandom_range(0, 3));
    end

    @(posedge clk); #1;
    tr_active = 1'b0;
    repeat (3) @(posedge clk);
    #6;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
